// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state encoding and default widths for the ROM stream reader.
`default_nettype none

package rom_stream_pkg;

   localparam int ROM_ADDR_W     = 8;
   localparam int ROM_DATA_W     = 8;
   localparam int ROM_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rom_stream_fifo.sv
// rom_stream_fifo: small synchronous FIFO with a combinational head output.
`default_nettype none

module rom_stream_fifo
   import rom_stream_pkg::*;
#(
   parameter int WIDTH = ROM_DATA_W + 1,
   parameter int DEPTH = ROM_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = count[PTR_W];
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: turns (start address, length) requests into a valid/ready byte stream
// read from a combinational ROM, buffered by a small FIFO against back-pressure.
`default_nettype none

module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_W     = ROM_ADDR_W,
   parameter int DATA_W     = ROM_DATA_W,
   parameter int FIFO_DEPTH = ROM_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_read_en,
   output logic              rom_ce,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              done_nxt;
   logic              issue;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W:0]   fifo_head;
   logic              head_last;
   logic              last_word;

   assign pop       = ~fifo_empty & out_ready;
   assign head_last = fifo_head[0];
   assign last_word = (remaining == (ADDR_W+1)'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_nxt = S_READ;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         S_READ: begin
            issue = (remaining != '0) && (!fifo_full || pop);
            if ((remaining == '0) || (issue && last_word)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Only the final word carries the last flag, so popping it ends the drain.
            if (fifo_empty || (pop && head_last)) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         remaining <= '0;
         done      <= 1'b0;
      end else begin
         done <= done_nxt;
         if ((state == S_IDLE) && start && (length != '0)) begin
            addr      <= start_addr;
            remaining <= length;
         end else if (issue) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

   rom_stream_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .pop   (pop),
      .din   ({rom_data, last_word}),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy        = (state != S_IDLE);
   assign rom_address = addr;
   assign rom_read_en = issue;
   assign rom_ce      = issue;
   assign out_valid   = ~fifo_empty;
   assign out_data    = fifo_empty ? '0 : fifo_head[DATA_W:1];
   assign out_last    = ~fifo_empty & head_last;

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized self-checking bench against a queue/arithmetic stream model.
`timescale 1ns/1ps
`default_nettype none

module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] start_addr;
   logic [8:0] length;
   logic       busy;
   logic       done;
   logic [7:0] rom_address;
   logic       rom_read_en;
   logic       rom_ce;
   logic [7:0] rom_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   int errors = 0;
   int checks = 0;
   logic [7:0] got_q [$];

   always #5 clk = ~clk;

   // ROM preloaded with mem[i] = i ^ 8'hA5, combinational read
   assign rom_data = rom_address ^ 8'hA5;

   rom_stream_reader #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .rom_address (rom_address),
      .rom_read_en (rom_read_en),
      .rom_ce      (rom_ce),
      .rom_data    (rom_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
   // noise: pulse start with random parameters while busy (must be ignored).
   // chain: drive the next request in the expected done cycle; prestarted: that already happened.
   task automatic run_req(input logic [7:0] sa, input int len, input int mode, input bit noise,
                          input bit prestarted, input bit chain, input logic [7:0] nsa, input int nlen);
      int cyc, rd_idx, pop_idx, occ, last_pop, first_valid;
      bit pv, pr, plast, exp_issue, popped, fin, done_due;
      logic [7:0] pdata, ea, ew;
      got_q.delete();
      rd_idx = 0; pop_idx = 0; occ = 0; last_pop = -10; first_valid = -1;
      pv = 1'b0; pr = 1'b0; plast = 1'b0; pdata = '0; fin = 1'b0;
      if (!prestarted) begin
         @(negedge clk);
         start = 1'b1; start_addr = sa; length = 9'(len); out_ready = 1'b1;
         #1;
         checks++;
         if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_at_start: got %b want 0", busy);
         end
      end
      cyc = 0;
      while (!fin) begin
         cyc++;
         @(negedge clk);
         done_due = (pop_idx == len) && (cyc == last_pop + 1);
         start = 1'b0;
         if (chain && done_due) begin
            start = 1'b1; start_addr = nsa; length = 9'(nlen);
         end else if (noise && !done_due && $urandom_range(0, 2) == 0) begin
            start = 1'b1; start_addr = 8'($urandom); length = 9'($urandom_range(0, 256));
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 2);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         popped    = out_valid && out_ready;
         exp_issue = (rd_idx < len) && (occ < 2 || popped);
         checks++;
         if (busy !== !done_due) begin
            errors++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, !done_due);
         end
         checks++;
         if (out_valid !== (occ != 0)) begin
            errors++; $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, occ != 0);
         end
         checks++;
         if (rom_read_en !== exp_issue) begin
            errors++; $display("FAIL rom_read_en cyc=%0d: got %b want %b", cyc, rom_read_en, exp_issue);
         end
         checks++;
         if (rom_ce !== exp_issue) begin
            errors++; $display("FAIL rom_ce cyc=%0d: got %b want %b", cyc, rom_ce, exp_issue);
         end
         if (exp_issue) begin
            ea = sa + 8'(rd_idx);
            checks++;
            if (rom_address !== ea) begin
               errors++; $display("FAIL rom_address cyc=%0d: got %h want %h", cyc, rom_address, ea);
            end
         end
         if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast) begin
               errors++;
               $display("FAIL stall_hold cyc=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        cyc, out_valid, out_data, out_last, pdata, plast);
            end
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (popped) begin
            got_q.push_back(out_data);
            checks++;
            if (pop_idx >= len) begin
               errors++; $display("FAIL extra_word cyc=%0d: got %h want none", cyc, out_data);
            end else begin
               ew = (sa + 8'(pop_idx)) ^ 8'hA5;
               if (out_data !== ew || out_last !== (pop_idx == len - 1)) begin
                  errors++;
                  $display("FAIL word%0d: got d=%h l=%b want d=%h l=%b",
                           pop_idx, out_data, out_last, ew, pop_idx == len - 1);
               end
            end
         end
         checks++;
         if (done !== done_due) begin
            errors++; $display("FAIL done cyc=%0d: got %b want %b", cyc, done, done_due);
         end
         if (exp_issue) begin
            rd_idx++; occ++;
         end
         if (popped) begin
            occ--; pop_idx++; last_pop = cyc;
         end
         pv = out_valid; pr = out_ready; pdata = out_data; plast = out_last;
         if (done_due || done) fin = 1'b1;
         if (!fin && cyc > 8 * len + 60) begin
            checks++; errors++; fin = 1'b1;
            $display("FAIL timeout: got %0d of %0d words", pop_idx, len);
         end
      end
      checks++;
      if (first_valid != 2) begin
         errors++; $display("FAIL first_valid_latency: got %0d want 2", first_valid);
      end
      checks++;
      if (pop_idx != len) begin
         errors++; $display("FAIL word_count: got %0d want %0d", pop_idx, len);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({busy, done, rom_read_en, rom_ce, out_valid, out_last} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 000000",
                            {busy, done, rom_read_en, rom_ce, out_valid, out_last});
      end
      checks++;
      if (rom_address !== 8'h00 || out_data !== 8'h00) begin
         errors++; $display("FAIL reset_buses: got addr=%h data=%h want 00 00", rom_address, out_data);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] expv [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
      run_req(8'h10, 4, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_q.size() <= i || got_q[i] !== expv[i]) begin
            errors++; $display("FAIL basic_const%0d: got %h want %h", i,
                               (got_q.size() > i) ? got_q[i] : 8'hxx, expv[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] expv [3] = '{8'h5B, 8'h5A, 8'hA5};
      run_req(8'hFE, 3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got_q.size() <= i || got_q[i] !== expv[i]) begin
            errors++; $display("FAIL wrap_const%0d: got %h want %h", i,
                               (got_q.size() > i) ? got_q[i] : 8'hxx, expv[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      run_req(8'($urandom), 8, 1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
   endtask

   task automatic test_len_zero();
      @(negedge clk);
      start = 1'b1; start_addr = 8'($urandom); length = '0; out_ready = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL len0_start: got busy=%b done=%b want 0 0", busy, done);
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if ({done, busy, out_valid, rom_ce} !== 4'b1000) begin
         errors++; $display("FAIL len0_done: got %b want 1000", {done, busy, out_valid, rom_ce});
      end
      @(negedge clk); #1;
      checks++;
      if ({done, busy, out_valid, rom_ce} !== 4'b0000) begin
         errors++; $display("FAIL len0_after: got %b want 0000", {done, busy, out_valid, rom_ce});
      end
   endtask

   task automatic test_full_length();
      run_req(8'h80, 256, 0, 1'b1, 1'b0, 1'b0, 8'h00, 0);
      checks++;
      if (got_q.size() != 256 || got_q[got_q.size() - 1] !== 8'hDA) begin
         errors++; $display("FAIL full_len_last: got n=%0d last=%h want n=256 last=da",
                            got_q.size(), (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'hxx);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      @(negedge clk);
      start = 1'b1; start_addr = 8'($urandom); length = 9'd10; out_ready = 1'b1;
      for (int i = 0; i < 20 && n < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (out_valid && out_ready) n++;
      end
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL reset_mid_progress: got %0d pops want 3", n);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, rom_read_en, rom_ce, out_valid, out_last, rom_address, out_data} !== '0) begin
         errors++; $display("FAIL reset_mid_outputs: got b=%b d=%b re=%b v=%b a=%h o=%h want all 0",
                            busy, done, rom_read_en, out_valid, rom_address, out_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++;
         if ({done, busy, out_valid} !== 3'b000) begin
            errors++; $display("FAIL reset_mid_quiet%0d: got %b want 000", i, {done, busy, out_valid});
         end
      end
      run_req(8'($urandom), 5, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a2;
      a2 = 8'($urandom);
      run_req(8'($urandom), 5, 0, 1'b0, 1'b0, 1'b1, a2, 3);
      run_req(a2, 3, 2, 1'b0, 1'b1, 1'b0, 8'h00, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         run_req(8'($urandom), $urandom_range(1, 20), 2, 1'b1, 1'b0, 1'b0, 8'h00, 0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_full_length();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
